// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and its multiply/divide sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: ALUop and funct codes, 4-bit main-ALU op encodings, sequencer state encoding.
// The DIV state only exists when ALU_CTRL_DIV_EN is defined.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef ALU_CTRL_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_md_seq.sv
// md_seq: iterative shift-add multiplier / restoring divider with a final sign-fix cycle.
// Latency: WIDTH step cycles plus one FIX cycle after the start edge; results valid while fix=1.
// Backpressure: none; start is ignored unless idle, the parent stalls new requests while busy.
// Ports: clk, rst_n (sync, active low); start_mul/start_div (start_div only with ALU_CTRL_DIV_EN),
//        sgn (signed operation), a/b (raw operands); busy, fix, res_hi/res_lo (sign-corrected result).
module md_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
`ifdef ALU_CTRL_DIV_EN
  input  logic             start_div,
`endif
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fix,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // acc: product high half / partial remainder. qr: multiplier then product low half /
  // dividend then quotient. opnd: multiplicand / divisor magnitude.
  logic [WIDTH-1:0] acc, acc_nxt, qr, qr_nxt, opnd, opnd_nxt;
  logic             neg_lo, neg_lo_nxt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_CTRL_DIV_EN
  logic             neg_hi, neg_hi_nxt, div_op, div_op_nxt;
  logic [WIDTH:0]   div_t;
`endif

  // |MIN| wraps to MIN, which read as unsigned is exactly the right magnitude.
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  assign busy  = (state != ST_IDLE);
  assign fix   = (state == ST_FIX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      qr     <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      neg_hi <= 1'b0;
      div_op <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      qr     <= qr_nxt;
      opnd   <= opnd_nxt;
      neg_lo <= neg_lo_nxt;
`ifdef ALU_CTRL_DIV_EN
      neg_hi <= neg_hi_nxt;
      div_op <= div_op_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    qr_nxt     = qr;
    opnd_nxt   = opnd;
    neg_lo_nxt = neg_lo;
    mul_sum    = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
`ifdef ALU_CTRL_DIV_EN
    neg_hi_nxt = neg_hi;
    div_op_nxt = div_op;
    div_t      = {acc, qr[WIDTH-1]};
`endif
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start_mul) begin
          state_nxt  = ST_MUL;
          acc_nxt    = '0;
          qr_nxt     = b_mag;
          opnd_nxt   = a_mag;
          neg_lo_nxt = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_CTRL_DIV_EN
          neg_hi_nxt = 1'b0;
          div_op_nxt = 1'b0;
        end else if (start_div) begin
          state_nxt  = ST_DIV;
          acc_nxt    = '0;
          qr_nxt     = a_mag;
          opnd_nxt   = b_mag;
          neg_lo_nxt = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          // Remainder takes the dividend's sign.
          neg_hi_nxt = sgn & a[WIDTH-1];
          div_op_nxt = 1'b1;
`endif
        end
      end
      ST_MUL: begin
        // Add-then-shift right: the carry out lands in acc, low bits slide into qr.
        acc_nxt = mul_sum[WIDTH:1];
        qr_nxt  = {mul_sum[0], qr[WIDTH-1:1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
      end
`ifdef ALU_CTRL_DIV_EN
      ST_DIV: begin
        // Divisor 0 always subtracts: quotient becomes all ones, remainder the dividend.
        if (div_t >= {1'b0, opnd}) begin
          acc_nxt = div_t[WIDTH-1:0] - opnd;
          qr_nxt  = {qr[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt = div_t[WIDTH-1:0];
          qr_nxt  = {qr[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
      end
`endif
      ST_FIX: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign prod = {acc, qr};

  always_comb begin
    {res_hi, res_lo} = neg_lo ? -prod : prod;
`ifdef ALU_CTRL_DIV_EN
    if (div_op) begin
      res_hi = neg_hi ? -acc : acc;
      res_lo = neg_lo ? -qr : qr;
    end
`endif
  end

endmodule

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decode plus HI/LO registers fed by an iterative MULT/DIV sequencer.
// Latency: decode is combinational; MULT/DIV hold busy_o for WIDTH+1 cycles, HI/LO readable as busy_o falls.
// Backpressure: stall_o holds any HI/LO-class instruction while busy; other instructions never stall.
// Ports: clk, rst_n (sync, active low); valid_i, alu_op_i, funct_i, rs_i, rt_i from EX;
//        op_o, illegal_o (decode); hilo_sel_o, hilo_o (MFHI/MFLO read); busy_o, stall_o, md_done_o.
// Build option: define ALU_CTRL_DIV_EN to enable DIV/DIVU; otherwise they decode as illegal.
module alu_ctrl_md
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic [3:0]       op_o,
  output logic             illegal_o,
  output logic             hilo_sel_o,
  output logic [WIDTH-1:0] hilo_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             md_done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, md_class;
  logic             busy, fix, start_mul, md_done;
  logic [WIDTH-1:0] hi, lo, res_hi, res_lo;

  always_comb begin
    op_o      = OP_ADD;
    illegal_o = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: op_o = OP_ADD;
      ALUOP_SUB: op_o = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU:  op_o = OP_ADD;
          FN_SUB, FN_SUBU:  op_o = OP_SUB;
          FN_AND:           op_o = OP_AND;
          FN_OR:            op_o = OP_OR;
          FN_XOR:           op_o = OP_XOR;
          FN_NOR:           op_o = OP_NOR;
          FN_SLT:           op_o = OP_SLT;
          FN_MULT, FN_MULTU: is_mul = 1'b1;
`ifdef ALU_CTRL_DIV_EN
          FN_DIV, FN_DIVU:  is_div = 1'b1;
`endif
          FN_MFHI:          is_mfhi = 1'b1;
          FN_MFLO:          is_mflo = 1'b1;
          FN_MTHI:          is_mthi = 1'b1;
          FN_MTLO:          is_mtlo = 1'b1;
          default:          illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign md_class   = is_mul | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo;
  // The sequencer is idle exactly when not busy, so this also covers "state != IDLE".
  assign stall_o    = valid_i & md_class & busy;
  assign start_mul  = valid_i & is_mul & ~busy;
  assign hilo_sel_o = valid_i & (is_mfhi | is_mflo);
  assign hilo_o     = is_mfhi ? hi : (is_mflo ? lo : '0);
  assign busy_o     = busy;
  assign md_done_o  = md_done;

  md_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_mul (start_mul),
`ifdef ALU_CTRL_DIV_EN
    .start_div (valid_i & is_div & ~busy),
`endif
    .sgn       (~funct_i[0]),
    .a         (rs_i),
    .b         (rt_i),
    .busy      (busy),
    .fix       (fix),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // FIX and MTHI/MTLO can never coincide: MTHI/MTLO only write while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= fix;
      if (fix) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (valid_i && !busy) begin
        if (is_mthi) hi <= rs_i;
        if (is_mtlo) lo <= rs_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Bench for alu_ctrl_md: directed literal checks plus randomized traffic against a
// cycle-level behavioural model (plain 64-bit arithmetic for MULT/DIV results).
module tb_alu_ctrl_md;
  localparam int W = 32;
  localparam int K_NONE = 0, K_MUL = 1, K_DIV = 2, K_MFHI = 3, K_MFLO = 4, K_MTHI = 5, K_MTLO = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_next = 1'b0;
  logic valid = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'd0;
  logic [W-1:0] rs = '0, rt = '0;
  logic [3:0] op_o;
  logic illegal_o, hilo_sel_o, busy_o, stall_o, md_done_o;
  logic [W-1:0] hilo_o;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .alu_op_i(alu_op), .funct_i(funct),
    .rs_i(rs), .rt_i(rt), .op_o(op_o), .illegal_o(illegal_o), .hilo_sel_o(hilo_sel_o),
    .hilo_o(hilo_o), .busy_o(busy_o), .stall_o(stall_o), .md_done_o(md_done_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic ref_decode(input logic [1:0] aop, input logic [5:0] fn,
                            output logic [3:0] op, output logic ill, output int kind);
    op = 4'b0010; ill = 1'b0; kind = K_NONE;
    if (aop == 2'b01) op = 4'b0110;
    else if (aop == 2'b11) ill = 1'b1;
    else if (aop == 2'b10) begin
      case (fn)
        6'b100000, 6'b100001: op = 4'b0010;
        6'b100010, 6'b100011: op = 4'b0110;
        6'b100100: op = 4'b0000;
        6'b100101: op = 4'b0001;
        6'b100110: op = 4'b0011;
        6'b100111: op = 4'b1100;
        6'b101010: op = 4'b0111;
        6'b011000, 6'b011001: kind = K_MUL;
`ifdef ALU_CTRL_DIV_EN
        6'b011010, 6'b011011: kind = K_DIV;
`endif
        6'b010000: kind = K_MFHI;
        6'b010010: kind = K_MFLO;
        6'b010001: kind = K_MTHI;
        6'b010011: kind = K_MTLO;
        default: ill = 1'b1;
      endcase
    end
  endtask

  task automatic md_result(input int kind, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] h, output logic [W-1:0] l);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (kind == K_MUL) begin
      if (sg) begin
        sp = longint'(sa) * longint'(sb);
        {h, l} = sp;
      end else begin
        up = {32'd0, a} * {32'd0, b};
        {h, l} = up;
      end
    end else if (sg) begin
      if (b == 0) begin
        // all-ones quotient magnitude, negated when the dividend is negative
        l = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        h = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        l = a;
        h = '0;
      end else begin
        l = sa / sb;
        h = sa % sb;
      end
    end else if (b == 0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else begin
      l = a / b;
      h = a % b;
    end
  endtask

  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int m_left = 0;
  logic m_done = 1'b0;
  bit started = 1'b0;

  // Compare process: checks every cycle just before the rising edge, then advances the model.
  initial begin
    logic [3:0] e_op;
    logic e_ill, e_busy;
    int kind;
    forever begin
      @(negedge clk);
      #4;
      ref_decode(alu_op, funct, e_op, e_ill, kind);
      e_busy = (m_left > 0);
      if (started) begin
        chk("op", {60'd0, op_o}, {60'd0, e_op});
        chk("illegal", {63'd0, illegal_o}, {63'd0, e_ill});
        chk("busy", {63'd0, busy_o}, {63'd0, e_busy});
        chk("stall", {63'd0, stall_o}, {63'd0, valid && kind != K_NONE && e_busy});
        chk("hilo_sel", {63'd0, hilo_sel_o}, {63'd0, valid && (kind == K_MFHI || kind == K_MFLO)});
        chk("hilo", {32'd0, hilo_o}, {32'd0, (kind == K_MFHI) ? m_hi : (kind == K_MFLO) ? m_lo : 32'd0});
        chk("md_done", {63'd0, md_done_o}, {63'd0, m_done});
      end
      if (!rst_n) begin
        m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; started = 1'b1;
      end else begin
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end else if (valid) begin
          if (kind == K_MUL || kind == K_DIV) begin
            md_result(kind, ~funct[0], rs, rt, p_hi, p_lo);
            m_left = W + 1;
          end else if (kind == K_MTHI) m_hi = rs;
          else if (kind == K_MTLO) m_lo = rs;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst_n = rst_next; valid = v; alu_op = aop; funct = fn; rs = a; rt = b;
    #4;
  endtask

  task automatic nop();
    drive(1'b0, 2'b00, 6'd0, '0, '0);
  endtask

  // Counts busy cycles after an issue; leaves the bench in the first idle cycle.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      nop();
      if (!busy_o) break;
      n++;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: pick = '0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = W'($urandom % 16);
      default: pick = $urandom;
    endcase
  endfunction

  logic [5:0] fn_tab [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b101010, 6'b011000, 6'b011001, 6'b011010,
                              6'b011011, 6'b010000, 6'b010001, 6'b010010, 6'b010011};

  initial begin
    int n;
    rst_next = 1'b0;
    nop();
    nop();
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, md_done_o}, 64'd0);
    rst_next = 1'b1;
    drive(1'b1, 2'b10, 6'b010000, '0, '0);
    chk("rst_hi", {32'd0, hilo_o}, 64'd0);

    // decode sweep
    drive(1'b0, 2'b10, 6'b100010, '0, '0); chk("dec_sub", {60'd0, op_o}, 64'h6);
    drive(1'b0, 2'b10, 6'b100111, '0, '0); chk("dec_nor", {60'd0, op_o}, 64'hC);
    drive(1'b0, 2'b10, 6'b101010, '0, '0); chk("dec_slt", {60'd0, op_o}, 64'h7);
    drive(1'b0, 2'b10, 6'b111111, '0, '0); chk("dec_bad_op", {60'd0, op_o}, 64'h2);
    chk("dec_bad_ill", {63'd0, illegal_o}, 64'd1);
    drive(1'b0, 2'b01, 6'b000000, '0, '0); chk("dec_aop01", {60'd0, op_o}, 64'h6);

    // MULT -3 * 7
    drive(1'b1, 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7);
    count_busy(n);
    chk("mult_busy_cycles", 64'(n), 64'd33);
    chk("mult_done", {63'd0, md_done_o}, 64'd1);
    drive(1'b1, 2'b10, 6'b010000, '0, '0);
    chk("mult_hi", {32'd0, hilo_o}, 64'hFFFF_FFFF);
    chk("mult_hisel", {63'd0, hilo_sel_o}, 64'd1);
    drive(1'b1, 2'b10, 6'b010010, '0, '0);
    chk("mult_lo", {32'd0, hilo_o}, 64'hFFFF_FFEB);

`ifdef ALU_CTRL_DIV_EN
    drive(1'b1, 2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    drive(1'b1, 2'b10, 6'b010010, '0, '0); chk("div_lo", {32'd0, hilo_o}, 64'hFFFF_FFFD);
    drive(1'b1, 2'b10, 6'b010000, '0, '0); chk("div_hi", {32'd0, hilo_o}, 64'hFFFF_FFFF);
    drive(1'b1, 2'b10, 6'b011011, 32'd10, 32'd0);
    count_busy(n);
    drive(1'b1, 2'b10, 6'b010010, '0, '0); chk("divu0_lo", {32'd0, hilo_o}, 64'hFFFF_FFFF);
    drive(1'b1, 2'b10, 6'b010000, '0, '0); chk("divu0_hi", {32'd0, hilo_o}, 64'h0000_000A);
`else
    drive(1'b1, 2'b10, 6'b011010, 32'd9, 32'd3);
    chk("nodiv_ill", {63'd0, illegal_o}, 64'd1);
    chk("nodiv_stall", {63'd0, stall_o}, 64'd0);
    nop();
    chk("nodiv_busy", {63'd0, busy_o}, 64'd0);
    drive(1'b1, 2'b10, 6'b010011, 32'h0000_1234, '0);
    drive(1'b1, 2'b10, 6'b010010, '0, '0); chk("mtlo_lo", {32'd0, hilo_o}, 64'h0000_1234);
`endif

    // stall handshake: ADD in cycle 4, MFLO from cycle 5 after issue
    drive(1'b1, 2'b10, 6'b011000, 32'h0000_1234, 32'h0000_0100);
    repeat (3) nop();
    drive(1'b1, 2'b10, 6'b100000, 32'd1, 32'd2);
    chk("add_nostall", {63'd0, stall_o}, 64'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 2'b10, 6'b010010, '0, '0);
      if (!stall_o) break;
      n++;
    end
    chk("mflo_stall_cycles", 64'(n), 64'd29);
    chk("mflo_after_busy", {63'd0, busy_o}, 64'd0);
    chk("mflo_value", {32'd0, hilo_o}, 64'h0012_3400);

    // reset in cycle 10 of a MULTU
    drive(1'b1, 2'b10, 6'b011001, 32'd9, 32'd9);
    repeat (9) nop();
    rst_next = 1'b0;
    nop();
    rst_next = 1'b1;
    drive(1'b1, 2'b10, 6'b010000, '0, '0);
    chk("rstmid_busy", {63'd0, busy_o}, 64'd0);
    chk("rstmid_hi", {32'd0, hilo_o}, 64'd0);
    drive(1'b1, 2'b10, 6'b010010, '0, '0);
    chk("rstmid_lo", {32'd0, hilo_o}, 64'd0);
    drive(1'b1, 2'b10, 6'b011001, 32'd5, 32'd6);
    count_busy(n);
    chk("multu_busy_cycles", 64'(n), 64'd33);
    drive(1'b1, 2'b10, 6'b010010, '0, '0);
    chk("multu_lo", {32'd0, hilo_o}, 64'h0000_001E);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] aop;
      logic [5:0] fn;
      rst_next = ($urandom % 300) != 0;
      aop = (($urandom % 8) < 6) ? 2'b10 : 2'($urandom);
      fn = (($urandom % 10) == 0) ? 6'($urandom) : fn_tab[$urandom % 17];
      drive(($urandom % 4) != 0, aop, fn, pick(), pick());
    end
    rst_next = 1'b1;
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUop/funct into the 4-bit main-ALU operation and extends the R-type set (ADDU, SUBU, XOR, NOR).
- Adds an iterative multiply/divide sequencer with HI/LO registers and a stall handshake to the EX stage.
- Sits between the main control unit and the EX stage ALU / result mux.

Parameters:
- WIDTH, 32, datapath width of operands and of HI/LO; legal range is WIDTH >= 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_i  in  1  EX-stage instruction valid
- alu_op_i  in  2  ALUop from main control
- funct_i  in  6  R-type funct field
- rs_i  in  WIDTH  operand A
- rt_i  in  WIDTH  operand B
- op_o  out  4  main-ALU operation code
- illegal_o  out  1  undecodable ALUop/funct
- hilo_sel_o  out  1  EX result mux selects hilo_o (MFHI/MFLO)
- hilo_o  out  WIDTH  HI or LO read data
- busy_o  out  1  sequencer active
- stall_o  out  1  hold EX instruction this cycle
- md_done_o  out  1  one-cycle pulse when HI/LO are written by MULT/DIV

Behaviour:
- Decode (combinational):
  - alu_op 00 -> 0010 (ADD).
  - alu_op 01 -> 0110 (SUB).
  - alu_op 11 -> 0010 with illegal_o=1.
  - alu_op 10 with funct:
    - 100000/100001 -> 0010
    - 100010/100011 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 100110 -> 0011
    - 100111 -> 1100
    - 101010 -> 0111
    - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011 -> op_o=0010, illegal_o=0.
    - Any other funct -> 0010, illegal_o=1.
  - op_o never latches.
- md-class: alu_op=10 and funct is one of the eight MULT/DIV/HI/LO codes above.
- hilo_sel_o=1 for MFHI/MFLO with valid_i. hilo_o = HI for MFHI, LO for MFLO, 0 otherwise.
- stall_o = valid_i & md-class & (busy_o | state != IDLE). Non-md instructions are never stalled.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL/DIV on valid_i & MULT(U)/DIV(U) & !stall_o. On that edge: latch |rs|, |rt| (signed variants) or raw values (unsigned); record result signs; counter=0.
  - MUL: one shift-add step per cycle, WIDTH cycles, then -> FIX.
  - DIV: one restoring-divide step per cycle, WIDTH cycles, then -> FIX.
  - FIX: apply sign correction. On the exit edge write HI/LO, pulse md_done_o, -> IDLE.
- Timing: busy_o=1 in MUL, DIV and FIX, i.e. WIDTH+1 cycles after the issue edge. HI/LO are readable the cycle busy_o falls.
- MUL result: HI:LO = 2*WIDTH-bit product.
- DIV result: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- Divide by zero: LO = all ones (unsigned) or result of sign fixup (signed); HI = dividend. No trap.
- Signed MIN / -1: LO = MIN, HI = 0.
- MTHI/MTLO: write rs_i to HI/LO on the edge when valid_i & IDLE. When busy they stall.
- MFHI/MFLO while busy: stalled. Never return stale data.
- A second MULT/DIV while busy: stalled, not accepted. Accepted the cycle after return to IDLE.
- valid_i=0: no state change and no HI/LO writes; decode outputs still follow the inputs.
- Reset (rst_n=0 at an edge, including mid-operation): state=IDLE, counter=0, HI=LO=0, busy_o=0, md_done_o=0. Any in-flight operation is abandoned.

Optional Feature:
- Macro: ALU_CTRL_DIV_EN.
- Defined: DIV/DIVU are supported as above.
- Undefined:
  - The DIV state and divider datapath are absent.
  - DIV/DIVU decode with illegal_o=1, never start the sequencer, and never stall.
  - HI/LO are unchanged.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALUop constants and funct constants
  - 4-bit op encodings
  - FSM state encoding
- Sub-module md_seq holds the MUL/DIV/FIX iteration datapath and counter.
- alu_ctrl_md keeps the decode, stall logic, HI/LO registers and MTHI/MTLO logic.

Test Plan:
- Decode sweep, alu_op=10:
  - funct 100010 -> op_o=0110; 100111 -> 1100; 101010 -> 0111; 111111 -> 0010, illegal_o=1.
  - alu_op=01 -> 0110.
- MULT, WIDTH=32, rs=-3, rt=7:
  - busy_o high 33 cycles, then md_done_o pulse.
  - HI=FFFFFFFF, LO=FFFFFFEB.
  - MFHI returns FFFFFFFF with hilo_sel_o=1.
- DIV with ALU_CTRL_DIV_EN:
  - rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
  - DIVU rs=10, rt=0 -> LO=FFFFFFFF, HI=0000000A.
- Stall handshake:
  - MFLO presented 5 cycles after MULT issue -> stall_o=1 until busy_o falls, then LO is read.
  - ADD presented meanwhile -> stall_o=0.
- Reset mid-MULT at cycle 10:
  - Next cycle busy_o=0, HI=LO=0.
  - New MULTU 5*6 completes with LO=0000001E.
- Build without ALU_CTRL_DIV_EN:
  - DIV presented -> illegal_o=1, busy_o stays 0.
  - MTLO rs=1234 -> LO=00001234.
